// File: rtl/bg_object_renderer.sv
// Background object renderer: turns the two spawner positions into per-pixel
// sprite-on signals. Positions are frame-latched so a frame never tears. Each
// sprite row for the next scanline is prefetched in horizontal blank. The row
// is shifted out during the line with one cycle of registered latency.
module bg_object_renderer #(
  parameter int CONV    = 0,
  parameter int OBJ1_Y  = 40,
  parameter int OBJ2_Y  = 72,
  parameter int H_FETCH = 640,
  parameter int V_TOTAL = 525
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [9:CONV]   bg_object1_pos,
  input  logic [9:CONV]   bg_object2_pos,
  input  logic [9:0]      hpos,
  input  logic [9:0]      vpos,
  input  logic            display_on,
  input  logic            frame_start,
  output logic            bg_pixel_on,
  output logic [1:0]      bg_obj_hit
);

  localparam logic [9:0] LP_OBJ1_TOP = 10'(OBJ1_Y);
  localparam logic [9:0] LP_OBJ1_END = 10'(OBJ1_Y + 8);
  localparam logic [9:0] LP_OBJ2_TOP = 10'(OBJ2_Y);
  localparam logic [9:0] LP_OBJ2_END = 10'(OBJ2_Y + 8);
  localparam logic [9:0] LP_H_FETCH  = 10'(H_FETCH);
  localparam logic [9:0] LP_V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:CONV] LP_POS_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_F1   = 2'd1,
    ST_F2   = 2'd2
  } state_t;

  // 8x16 cloud sprite, bit 15 is the leftmost pixel
  function automatic logic [15:0] sprite_row(input logic [2:0] idx);
    logic [15:0] row;
    case (idx)
      3'd0:    row = 16'h0E70;
      3'd1:    row = 16'h3FFC;
      3'd2:    row = 16'h7FFE;
      3'd3:    row = 16'hFFFF;
      3'd4:    row = 16'hFFFF;
      3'd5:    row = 16'h7FFE;
      3'd6:    row = 16'h3FFC;
      3'd7:    row = 16'h0FF0;
      default: row = 16'h0000;
    endcase
    return row;
  endfunction

  logic [9:CONV] r_shadow1;
  logic [9:CONV] r_shadow2;
  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_fetch1;
  logic          w_fetch2;
  logic [9:0]    w_next_line;
  logic [2:0]    w_row_idx1;
  logic [2:0]    w_row_idx2;
  logic          w_in_obj1;
  logic          w_in_obj2;
  logic [15:0]   r_pend1;
  logic [15:0]   r_pend2;
  logic          r_pvalid1;
  logic          r_pvalid2;
  logic [15:0]   r_row1;
  logic [15:0]   r_row2;
  logic          r_rvalid1;
  logic          r_rvalid2;
  logic [15:0]   r_shift1;
  logic [15:0]   r_shift2;
  logic [4:0]    r_run1;
  logic [4:0]    r_run2;
  logic [9:0]    w_x1;
  logic [9:0]    w_x2;
  logic          w_start1;
  logic          w_start2;
  logic          w_lit1;
  logic          w_lit2;
  logic          r_pixel_on;
  logic [1:0]    r_hit;

  assign w_next_line = (vpos == LP_V_LAST) ? 10'd0 : vpos + 10'd1;
  assign w_row_idx1  = 3'(w_next_line - LP_OBJ1_TOP);
  assign w_row_idx2  = 3'(w_next_line - LP_OBJ2_TOP);
  assign w_in_obj1   = (w_next_line >= LP_OBJ1_TOP) && (w_next_line < LP_OBJ1_END);
  assign w_in_obj2   = (w_next_line >= LP_OBJ2_TOP) && (w_next_line < LP_OBJ2_END);

  // Screen x of each object: position with CONV low zero bits appended
  assign w_x1 = 10'(r_shadow1) << CONV;
  assign w_x2 = 10'(r_shadow2) << CONV;

  // Frame latch: shadows change only on frame_start, so rendering never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow1 <= '0;
      r_shadow2 <= '0;
    end else if (frame_start) begin
      r_shadow1 <= bg_object1_pos;
      r_shadow2 <= bg_object2_pos;
    end
  end

  // Prefetch FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Prefetch FSM next state: fetch object 1 then object 2 right after H_FETCH
  always_comb begin
    w_state_nxt = r_state;
    w_fetch1    = 1'b0;
    w_fetch2    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (hpos == LP_H_FETCH) begin
          w_state_nxt = ST_F1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_F1: begin
        w_fetch1    = 1'b1;
        w_state_nxt = ST_F2;
      end
      ST_F2: begin
        w_fetch2    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Pending rows for the next scanline, filled by the prefetch FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend1   <= 16'h0000;
      r_pend2   <= 16'h0000;
      r_pvalid1 <= 1'b0;
      r_pvalid2 <= 1'b0;
    end else begin
      if (w_fetch1) begin
        r_pvalid1 <= w_in_obj1;
        if (w_in_obj1) begin
          r_pend1 <= sprite_row(w_row_idx1);
        end
      end
      if (w_fetch2) begin
        r_pvalid2 <= w_in_obj2;
        if (w_in_obj2) begin
          r_pend2 <= sprite_row(w_row_idx2);
        end
      end
    end
  end

  // Line swap: prefetched rows become active at the start of every scanline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row1    <= 16'h0000;
      r_row2    <= 16'h0000;
      r_rvalid1 <= 1'b0;
      r_rvalid2 <= 1'b0;
    end else if (hpos == 10'd0) begin
      r_row1    <= r_pend1;
      r_row2    <= r_pend2;
      r_rvalid1 <= r_pvalid1;
      r_rvalid2 <= r_pvalid2;
    end
  end

  assign w_start1 = display_on && r_rvalid1 && (r_shadow1 != LP_POS_ZERO) && (hpos == w_x1);
  assign w_start2 = display_on && r_rvalid2 && (r_shadow2 != LP_POS_ZERO) && (hpos == w_x2);

  // Current lit bit per object; the start pixel comes straight from the row
  // so the output register carries it on the very next edge
  always_comb begin
    w_lit1 = 1'b0;
    w_lit2 = 1'b0;
    if (!display_on) begin
      w_lit1 = 1'b0;
    end else if (w_start1) begin
      w_lit1 = r_row1[15];
    end else if (r_run1 != 5'd0) begin
      w_lit1 = r_shift1[15];
    end else begin
      w_lit1 = 1'b0;
    end
    if (!display_on) begin
      w_lit2 = 1'b0;
    end else if (w_start2) begin
      w_lit2 = r_row2[15];
    end else if (r_run2 != 5'd0) begin
      w_lit2 = r_shift2[15];
    end else begin
      w_lit2 = 1'b0;
    end
  end

  // Shift engines: the start cycle emits bit 15, 15 more pixels follow;
  // leaving active video aborts the run, which clips at the right edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift1 <= 16'h0000;
      r_shift2 <= 16'h0000;
      r_run1   <= 5'd0;
      r_run2   <= 5'd0;
    end else begin
      if (!display_on) begin
        r_run1 <= 5'd0;
      end else if (w_start1) begin
        r_shift1 <= {r_row1[14:0], 1'b0};
        r_run1   <= 5'd15;
      end else if (r_run1 != 5'd0) begin
        r_shift1 <= {r_shift1[14:0], 1'b0};
        r_run1   <= r_run1 - 5'd1;
      end
      if (!display_on) begin
        r_run2 <= 5'd0;
      end else if (w_start2) begin
        r_shift2 <= {r_row2[14:0], 1'b0};
        r_run2   <= 5'd15;
      end else if (r_run2 != 5'd0) begin
        r_shift2 <= {r_shift2[14:0], 1'b0};
        r_run2   <= r_run2 - 5'd1;
      end
    end
  end

  // Registered outputs; overlapping objects are OR-ed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pixel_on <= 1'b0;
      r_hit      <= 2'b00;
    end else begin
      r_pixel_on <= w_lit1 | w_lit2;
      r_hit      <= {w_lit2, w_lit1};
    end
  end

  assign bg_pixel_on = r_pixel_on;
  assign bg_obj_hit  = r_hit;

endmodule

// File: tb/tb_bg_object_renderer.sv
// Scoreboard bench for bg_object_renderer: the driver pushes the expected
// output of every cycle, the monitor pops and compares after each edge.
module tb_bg_object_renderer;

  localparam int P_OBJ1_Y = 40;
  localparam int P_OBJ2_Y = 40;
  localparam int H_LINE   = 660;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] bg_object1_pos;
  logic [9:0] bg_object2_pos;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       frame_start;
  logic       bg_pixel_on;
  logic [1:0] bg_obj_hit;

  always #5 clk = ~clk;

  bg_object_renderer #(
    .CONV(0), .OBJ1_Y(P_OBJ1_Y), .OBJ2_Y(P_OBJ2_Y), .H_FETCH(640), .V_TOTAL(525)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .bg_object1_pos(bg_object1_pos), .bg_object2_pos(bg_object2_pos),
    .hpos(hpos), .vpos(vpos), .display_on(display_on), .frame_start(frame_start),
    .bg_pixel_on(bg_pixel_on), .bg_obj_hit(bg_obj_hit)
  );

  typedef struct {
    logic [2:0] e;
    int         h;
    int         v;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: frame shadows and which scanline's row is pending/active
  int m_sh1 = 0;
  int m_sh2 = 0;
  int m_pend_line = -1;
  int m_row_line  = -1;

  function automatic logic [15:0] ref_row(input int r);
    case (r)
      0: return 16'h0E70;
      1: return 16'h3FFC;
      2: return 16'h7FFE;
      3: return 16'hFFFF;
      4: return 16'hFFFF;
      5: return 16'h7FFE;
      6: return 16'h3FFC;
      7: return 16'h0FF0;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic ref_lit(input int sh, input int top, input int h, input bit disp, input int row_line);
    logic [15:0] row;
    int          bit_idx;
    if (sh == 0 || !disp) return 1'b0;
    if (row_line < top || row_line >= top + 8) return 1'b0;
    if (h < sh || h >= sh + 16) return 1'b0;
    row     = ref_row(row_line - top);
    bit_idx = 15 - (h - sh);
    return row[bit_idx];
  endfunction

  // One cycle of stimulus plus its expected registered response
  task automatic drive(input int h, input int v, input bit fs, input bit rst_low);
    exp_t t;
    bit   disp;
    bit   l1;
    bit   l2;
    @(negedge clk);
    disp        = (h < 640) && (v < 480);
    hpos        = 10'(h);
    vpos        = 10'(v);
    display_on  = disp;
    frame_start = fs;
    if (rst_low && rst_n) begin
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bg_pixel_on, bg_obj_hit} !== 3'b000) begin
        n_fail++;
        $display("FAIL async_reset h=%0d v=%0d got=%b exp=000", h, v, {bg_pixel_on, bg_obj_hit});
      end
    end
    rst_n = !rst_low;
    if (rst_low) begin
      t.e = 3'b000;
      m_sh1 = 0;
      m_sh2 = 0;
      m_pend_line = -1;
      m_row_line  = -1;
    end else begin
      l1  = ref_lit(m_sh1, P_OBJ1_Y, h, disp, m_row_line);
      l2  = ref_lit(m_sh2, P_OBJ2_Y, h, disp, m_row_line);
      t.e = {l1 | l2, l2, l1};
      if (fs) begin
        m_sh1 = int'(bg_object1_pos);
        m_sh2 = int'(bg_object2_pos);
      end
      if (h == 0) m_row_line = m_pend_line;
      if (h == 640) m_pend_line = (v == 524) ? 0 : v + 1;
    end
    t.h = h;
    t.v = v;
    exp_q.push_back(t);
  endtask

  task automatic run_line(input int v, input bit fs, input int rst_at, input int rst_len);
    for (int h = 0; h < H_LINE; h++) begin
      drive(h, v, fs && (h == 0), (rst_at >= 0) && (h >= rst_at) && (h < rst_at + rst_len));
    end
  endtask

  // Monitor: compare the registered output against the oldest expectation
  always @(posedge clk) begin
    exp_t t;
    #1;
    if (exp_q.size() > 0) begin
      t = exp_q.pop_front();
      n_checks++;
      if ({bg_pixel_on, bg_obj_hit} !== t.e) begin
        n_fail++;
        $display("FAIL pixel h=%0d v=%0d got=%b exp=%b", t.h, t.v, {bg_pixel_on, bg_obj_hit}, t.e);
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    bg_object1_pos = 10'd0;
    bg_object2_pos = 10'd0;
    hpos           = 10'd0;
    vpos           = 10'd0;
    display_on     = 1'b0;
    frame_start    = 1'b0;
    for (int i = 0; i < 3; i++) drive(0, 0, 1'b0, 1'b1);

    // Object 1 at x=100 on lines 40..47, moved to 99 mid-frame
    bg_object1_pos = 10'd100;
    run_line(0, 1'b1, -1, 0);
    for (int v = 38; v <= 48; v++) begin
      if (v == 42) bg_object1_pos = 10'd99;
      run_line(v, 1'b0, -1, 0);
    end
    run_line(0, 1'b1, -1, 0);
    run_line(39, 1'b0, -1, 0);
    run_line(40, 1'b0, -1, 0);

    // Right-edge clipping at x=630
    bg_object1_pos = 10'd630;
    run_line(0, 1'b1, -1, 0);
    run_line(39, 1'b0, -1, 0);
    run_line(40, 1'b0, -1, 0);

    // Overlapping objects at 200 and 208 on the same rows
    bg_object1_pos = 10'd200;
    bg_object2_pos = 10'd208;
    run_line(0, 1'b1, -1, 0);
    run_line(39, 1'b0, -1, 0);
    run_line(40, 1'b0, -1, 0);
    run_line(41, 1'b0, -1, 0);

    // Off-screen and parked objects draw nothing
    bg_object1_pos = 10'd700;
    bg_object2_pos = 10'd0;
    run_line(0, 1'b1, -1, 0);
    run_line(39, 1'b0, -1, 0);
    run_line(40, 1'b0, -1, 0);

    // Reset while object 1 is being drawn, then recovery on a new frame
    bg_object1_pos = 10'd100;
    run_line(0, 1'b1, -1, 0);
    run_line(39, 1'b0, -1, 0);
    run_line(40, 1'b0, 105, 5);
    run_line(41, 1'b0, -1, 0);
    run_line(0, 1'b1, -1, 0);
    run_line(39, 1'b0, -1, 0);
    run_line(40, 1'b0, -1, 0);

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bg_object_renderer.md
Name: bg_object_renderer

Overview:
Consumer side of the background-object position stream. It takes the two background object positions produced by the spawner and turns them into a per-pixel "background sprite on" signal for the VGA pixel mux. Positions are latched once per frame so that spawner updates never tear an image. The sprite row for the next scanline is prefetched during horizontal blank and shifted out with a one-cycle registered latency.

Parameters:
CONV, 0, position LSB index; screen x = {pos, CONV zeros}; must match spawner CONV
OBJ1_Y, 40, top scanline of object 1 sprite
OBJ2_Y, 72, top scanline of object 2 sprite
H_FETCH, 640, hpos value that triggers next-line prefetch
V_TOTAL, 525, total scanlines per frame, used for next-line wrap

Ports:
clk  input  1  pixel clock, one pixel per cycle
rst_n  input  1  asynchronous active-low reset
bg_object1_pos  input  [9:CONV]  object 1 position from spawner; 0 = parked/inactive
bg_object2_pos  input  [9:CONV]  object 2 position from spawner; 0 = parked/inactive
hpos  input  10  current horizontal pixel counter
vpos  input  10  current scanline counter
display_on  input  1  high in active video region
frame_start  input  1  one-cycle pulse at hpos==0, vpos==0
bg_pixel_on  output  1  registered; background sprite pixel lit
bg_obj_hit  output  2  registered; bit0 = object 1 lit, bit1 = object 2 lit

Behaviour:
- Reset (async, rst_n low): shadow positions=0, FSM=IDLE, row valids=0, shift regs=0, run counters=0, bg_pixel_on=0, bg_obj_hit=2'b00.
- Frame latch: on the frame_start cycle, copy both positions into shadow regs. Shadows hold for the whole frame, and all rendering uses only the shadows.
- x_n = {shadow_n, CONV'b0}, which is 10 bits. An object with shadow_n == 0 is never drawn.
- Sprite ROM: internal, 8 rows x 16 bits, 1bpp cloud shape. Read is combinational. Bit 15 is the leftmost pixel.
- next_line = (vpos == V_TOTAL-1) ? 0 : vpos+1.
- Prefetch FSM, states IDLE -> F1 -> F2 -> IDLE:
  - IDLE: go to F1 when hpos == H_FETCH.
  - F1: r1 = next_line - OBJ1_Y. If next_line >= OBJ1_Y and < OBJ1_Y+8, set pend1 = ROM[r1[2:0]] and pvalid1 = 1; otherwise pvalid1 = 0. Then go to F2.
  - F2: the same for object 2 (pend2, pvalid2). Then go to IDLE.
  - Each state takes 1 cycle.
- Line swap: at hpos == 0 (any vpos), copy pend_n and pvalid_n into the active row regs row_n / rvalid_n. Prefetch data therefore always applies to the line after the one where it was fetched.
- Shift engine, per object, independent:
  - Start: when display_on && rvalid_n && shadow_n != 0 && hpos == x_n, load shift_n = row_n and run_n = 16.
  - While run_n != 0: lit_n = shift_n[15]; shift_n shifts left 1 per clk; run_n decrements.
  - When display_on falls, run_n clears. Objects that run past hpos 639 are clipped.
  - x_n >= 640 never matches during display_on, so the object is not drawn.
- Outputs, 1-cycle latency: the pixel for hpos == h appears at the clk edge after h is sampled.
  - bg_obj_hit = {lit2, lit1}.
  - bg_pixel_on = lit1 | lit2. Overlapping objects are OR-ed.
- Simultaneous events: frame_start and a shift start in the same cycle use the old shadow for that cycle. Both objects starting on the same hpos is legal.
- Reset mid-frame: outputs go low immediately. Nothing is drawn until the next frame_start latches nonzero positions and a prefetch completes.
- Spawner reload (pos jumps to 0x3E0+) mid-frame has no effect until the next frame_start.

Test Plan:
1. Reset asserted mid-line with an object active -> bg_pixel_on=0 and bg_obj_hit=0 within the same cycle; stays 0 until the next frame_start.
2. CONV=0, obj1 pos=100, frame_start, scan line OBJ1_Y=40 -> bg_obj_hit[0] follows ROM row 0 across the edges after hpos 100..115. No pixel on lines 39 or 48.
3. obj2 pos=0, obj1 pos=700 -> bg_pixel_on stays 0 for the whole frame.
4. obj1 pos=630 on its row -> pixels for hpos 630..639 follow ROM bits 15..6; nothing after display_on falls.
5. OBJ1_Y=OBJ2_Y=40, pos1=200, pos2=208 -> bg_pixel_on is the OR of both patterns over hpos 208..215; bg_obj_hit shows both bits.
6. Change bg_object1_pos from 100 to 99 mid-frame at vpos=42 -> lines 42..47 still drawn at x=100; next frame draws at 99.
